// File: rtl/mmu_pkg.sv
// Shared definitions for the MMU access-port arbiter: idle bus values,
// access mode encodings and the lock state type.
package mmu_pkg;

  // Unmapped address driven when nobody holds the port; the MMU answers 0.
  localparam logic [31:0] IDLE_ADDRESS = 32'hFFFF_FFFF;
  localparam logic        WRITE_MODE   = 1'b1;
  localparam logic        READ_MODE    = 1'b0;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: grants the first asserted request
// found when searching upward from last+1, wrapping modulo NUM_REQUESTERS.
module round_robin_picker
  import mmu_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int IDX_W          = idx_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]          last,
  output logic [NUM_REQUESTERS-1:0] grant,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      grant_valid
);

  logic [IDX_W-1:0] cand_idx [NUM_REQUESTERS];

  // cand_idx[k] is the requester examined at search distance k+1 from last.
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, last} + (IDX_W+1)'(gi + 1);
    assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQUESTERS))
                        ? IDX_W'(sum - (IDX_W+1)'(NUM_REQUESTERS))
                        : sum[IDX_W-1:0];
  end

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk from the farthest candidate inward so the nearest one wins.
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      if (req[cand_idx[k]]) begin
        grant_idx   = cand_idx[k];
        grant_valid = 1'b1;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mmu_arbiter.sv
// Shares one MMU access port among NUM_REQUESTERS masters with round-robin
// priority, optional bounded locking, and one-cycle read-data return routing.
module mmu_arbiter
  import mmu_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int LOCK_MAX       = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQUESTERS-1:0]       req,
  input  logic [NUM_REQUESTERS-1:0]       we,
  input  logic [NUM_REQUESTERS-1:0]       lock,
  input  logic [NUM_REQUESTERS-1:0][31:0] addr,
  input  logic [NUM_REQUESTERS-1:0][31:0] wdata,
  output logic [NUM_REQUESTERS-1:0]       gnt,
  output logic [NUM_REQUESTERS-1:0]       rvalid,
  output logic [31:0]                     rdata,
  output logic [31:0]                     mmu_address,
  output logic                            mmu_mode,
  output logic [31:0]                     mmu_data_in,
  input  logic [31:0]                     mmu_data_out
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  // A locked access arriving with count already here is the last one allowed.
  localparam logic [CNT_W-1:0] COUNT_LIMIT = CNT_W'(LOCK_MAX - 1);

  lock_state_t      state_reg, state_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IDX_W-1:0] last_reg, last_next;
  logic             pending_valid_reg, pending_valid_next;
  logic [IDX_W-1:0] pending_idx_reg, pending_idx_next;

  logic [NUM_REQUESTERS-1:0] rr_gnt;
  logic [IDX_W-1:0]          rr_idx;
  logic                      rr_valid;

  logic [NUM_REQUESTERS-1:0] gnt_next;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_valid;

  round_robin_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .IDX_W         (IDX_W)
  ) u_picker (
    .req        (req),
    .last       (last_reg),
    .grant      (rr_gnt),
    .grant_idx  (rr_idx),
    .grant_valid(rr_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= UNLOCKED;
      owner_reg         <= '0;
      count_reg         <= '0;
      last_reg          <= IDX_W'(NUM_REQUESTERS - 1);
      pending_valid_reg <= 1'b0;
      pending_idx_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      owner_reg         <= owner_next;
      count_reg         <= count_next;
      last_reg          <= last_next;
      pending_valid_reg <= pending_valid_next;
      pending_idx_reg   <= pending_idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    count_next = count_reg;
    last_next  = last_reg;
    gnt_next   = '0;
    sel_idx    = rr_idx;
    sel_valid  = 1'b0;

    unique case (state_reg)
      UNLOCKED: begin
        gnt_next  = rr_gnt;
        sel_idx   = rr_idx;
        sel_valid = rr_valid;
        if (rr_valid) begin
          last_next = rr_idx;
          if (lock[rr_idx] && (LOCK_MAX > 1)) begin
            state_next = LOCKED;
            owner_next = rr_idx;
            count_next = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        // Only the owner may use the port; everyone else waits even if it idles.
        sel_idx            = owner_reg;
        sel_valid          = req[owner_reg];
        gnt_next[owner_reg] = req[owner_reg];
        last_next          = owner_reg;
        if (!req[owner_reg] || !lock[owner_reg] || (count_reg >= COUNT_LIMIT)) begin
          state_next = UNLOCKED;
          count_next = '0;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      default: begin
        state_next = UNLOCKED;
      end
    endcase

    pending_valid_next = sel_valid && (we[sel_idx] == READ_MODE);
    pending_idx_next   = sel_idx;
  end

  assign gnt         = gnt_next;
  assign mmu_address = sel_valid ? addr[sel_idx] : IDLE_ADDRESS;
  assign mmu_mode    = (sel_valid && we[sel_idx]) ? WRITE_MODE : READ_MODE;
  assign mmu_data_in = sel_valid ? wdata[sel_idx] : '0;
  assign rdata       = mmu_data_out;

  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_rvalid
    assign rvalid[gi] = pending_valid_reg && (pending_idx_reg == IDX_W'(gi));
  end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Shares the single `mmu` access port between `NUM_REQUESTERS` bus masters (CPU core, DMA engine, debug port). Each cycle it grants at most one request using round-robin priority, forwards that request's address/mode/write data to the MMU, and routes the MMU's one-cycle-latency read data back to the requester that issued it. An optional per-requester lock gives a requester consecutive cycles for read-modify-write sequences, bounded by a timeout.

## Interface
Parameters:
- `NUM_REQUESTERS`, 2: number of masters, 2..8.
- `LOCK_MAX`, 16: maximum consecutive locked grants before the lock is forcibly released.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `clock`  in  1  system clock.
  - `reset`  in  1  asynchronous, active-high reset.
- Requester side:
  - `req`  in  NUM_REQUESTERS  request valid, one bit per requester.
  - `we`  in  NUM_REQUESTERS  1 = write, 0 = read.
  - `lock`  in  NUM_REQUESTERS  keep the grant on this requester after this access.
  - `addr`  in  NUM_REQUESTERS×32  per-requester address.
  - `wdata`  in  NUM_REQUESTERS×32  per-requester write data.
  - `gnt`  out  NUM_REQUESTERS  one-hot or zero; an access is accepted when `req[i] & gnt[i]`.
  - `rvalid`  out  NUM_REQUESTERS  one-hot or zero; read data is valid for requester i.
  - `rdata`  out  32  read data, shared by all requesters and qualified by `rvalid`.
- MMU side:
  - `mmu_address`  out  32  to the MMU `address_in`.
  - `mmu_mode`  out  1  to the MMU `mode`; 1 = write.
  - `mmu_data_in`  out  32  to the MMU `data_in`.
  - `mmu_data_out`  in  32  from the MMU `data_out`, registered inside the MMU.

## Operation
- `gnt` is combinational from `req`, the priority pointer `last` and the lock state. The MMU outputs are muxed combinationally from the granted requester in the same cycle.
- No grant:
  - `mmu_mode` = 0.
  - `mmu_address` = `IDLE_ADDRESS` (32'hFFFF_FFFF). This is unmapped, so the MMU returns 0 and no peripheral sees a spurious read.
  - `mmu_data_in` = 0.
- Round-robin, unlocked:
  - Search starts at requester `last+1` (mod N) and grants the first asserted `req`.
  - On an accepted access, `last` updates to the granted index.
- Lock states: UNLOCKED and LOCKED(owner, count).
  - UNLOCKED→LOCKED: an access is accepted with `lock[i]`=1. Owner = i, count = 1.
  - In LOCKED, only the owner may be granted. Other requesters see `gnt`=0 even when the owner is idle.
  - LOCKED→UNLOCKED when any of the following holds:
    - the owner's accepted access has `lock`=0 (that access is still granted);
    - the owner deasserts `req` for a cycle;
    - count reaches `LOCK_MAX` on an accepted access (a forced release).
  - On a forced release, `last` = owner, so another requester wins next if requesting.
  - count increments on each accepted owner access and saturates at `LOCK_MAX`.
- Reads: when a read is accepted in cycle T, the index is registered in `pending` (valid + index). In T+1, `rvalid[index]`=1 and `rdata` = `mmu_data_out`.
- Writes produce no response. A write is complete when accepted.
- Back-to-back accesses from the same or different requesters are legal every cycle. `pending` is overwritten each cycle.
- `rdata` when `rvalid`=0: drives `mmu_data_out` unqualified. Consumers must gate on `rvalid`.

## Timing
- Reset values: `gnt`=0, `rvalid`=0, `mmu_mode`=0, `mmu_address`=`IDLE_ADDRESS`, `mmu_data_in`=0, `last`=N-1 (requester 0 has first priority), lock=UNLOCKED, count=0, pending invalid.
- Grant latency: 0 cycles (combinational). Read latency: exactly 1 cycle after acceptance. Throughput: 1 access per cycle.
- Requesters hold `addr`/`we`/`wdata`/`lock` stable while `req`=1 and `gnt`=0.
- Reset asserted while a read is pending: the read is dropped and `rvalid` stays 0 on the cycle after reset deasserts. Reset while LOCKED returns to UNLOCKED.
- Simultaneous requests from all masters: exactly one `gnt` bit is set, chosen by the pointer.
- `req` deasserted in the same cycle as the owner's lock would expire: treat as release by deassert. `last` = owner.

## Structure
- Add to a shared package `mmu_pkg`:
  - `IDLE_ADDRESS`;
  - `WRITE_MODE`/`READ_MODE`;
  - a `lock_state_t` enum (UNLOCKED, LOCKED).
- One sub-module: `round_robin_picker` (`req` vector, `last` index → one-hot grant + index), purely combinational.
- The lock FSM, count, `last` and `pending` registers live in `mmu_arbiter`.

## Test plan
- Two requesters read continuously, with addresses 0x10 and 0x60:
  - grants alternate 0,1,0,1 starting with 0 after reset;
  - each `rvalid` arrives 1 cycle after its grant with that address's MMU data.
- Requester 1 writes 0xDEADBEEF to 0x80, then requester 0 reads 0x80 on the next cycle: `mmu_mode`=1 in the write cycle, and `rdata`=0xDEADBEEF with `rvalid[0]` one cycle after the read grant.
- Requester 0 does a locked read then an unlocked write to 0x90 while requester 1 requests continuously: requester 1 gets no grant until the cycle after the write.
- Requester 0 holds `lock`=1 for 20 accepted cycles while requester 1 requests, with `LOCK_MAX`=16: requester 1 is granted on the 17th cycle.
- No requests: `mmu_address`=0xFFFF_FFFF, `mmu_mode`=0, `gnt`=0, `rvalid`=0.
- Reset pulsed in the cycle after a read grant: no `rvalid`; after reset, the first grant goes to requester 0.
